// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchroniser, debouncer, edge pulses and tick-cleared sticky press flags
// A press is latched until the next consumer tick edge; a second press before that edge raises overrun.
module input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] latched_o,
  output logic [WIDTH-1:0] overrun_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] tick_q;
  logic                   tick_hist_q;
  logic [CW-1:0]          cnt_q [WIDTH];

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] rise_now;
  logic             tick_edge;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign tick_edge = tick_q[SYNC_STAGES-1] & ~tick_hist_q;

  // update marks the cycle in which a channel's level flips
  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (sync[i] != level_o[i]) && (cnt_q[i] == CNT_LAST);
    end
    rise_now = update & sync;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      tick_q      <= '0;
      tick_hist_q <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      tick_q      <= {tick_q[SYNC_STAGES-2:0], tick_i};
      tick_hist_q <= tick_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_o <= '0;
      rise_o  <= '0;
      fall_o  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == level_o[i] || cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      level_o <= level_o ^ update;
      rise_o  <= rise_now;
      fall_o  <= update & ~sync;
    end
  end

  // A rise coinciding with a tick edge belongs to the new period, so set wins over clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      latched_o <= '0;
      overrun_o <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rise_now[i]) begin
          latched_o[i] <= 1'b1;
          if (tick_edge) begin
            overrun_o[i] <= 1'b0;
          end else if (latched_o[i]) begin
            overrun_o[i] <= 1'b1;
          end
        end else if (tick_edge) begin
          latched_o[i] <= 1'b0;
          overrun_o[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized bench for input_conditioner against a window-based reference model
module tb_input_conditioner;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] async_in = '0;
  logic         tick = 1'b0;
  logic [W-1:0] level, rise, fall, latched, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .async_i(async_in),
    .tick_i(tick),
    .level_o(level),
    .rise_o(rise),
    .fall_o(fall),
    .latched_o(latched),
    .overrun_o(overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: inputs delayed by SS edges; a level flips once the last DC samples all disagree with it
  bit [W-1:0] aq[$];
  bit         tq[$];
  bit         tick_prev;
  bit         win[W][$];
  bit [W-1:0] m_level, m_rise, m_fall, m_lat, m_ov;

  function automatic void model_reset();
    aq = {};
    tq = {};
    for (int k = 0; k < SS; k++) begin
      aq.push_back('0);
      tq.push_back(1'b0);
    end
    tick_prev = 1'b0;
    for (int i = 0; i < W; i++) win[i] = {};
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_lat   = '0;
    m_ov    = '0;
  endfunction

  function automatic void model_step();
    bit [W-1:0] s;
    bit ts, te, upd;
    s = aq.pop_front();
    aq.push_back(async_in);
    ts = tq.pop_front();
    tq.push_back(tick);
    te = ts && !tick_prev;
    tick_prev = ts;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      win[i].push_back(s[i]);
      if (win[i].size() > DC) void'(win[i].pop_front());
      upd = (win[i].size() == DC);
      for (int k = 0; k < win[i].size(); k++)
        if (win[i][k] == m_level[i]) upd = 1'b0;
      if (upd) begin
        m_level[i] = s[i];
        m_rise[i]  = s[i];
        m_fall[i]  = !s[i];
      end
      if (m_rise[i]) begin
        if (te) m_ov[i] = 1'b0;
        else if (m_lat[i]) m_ov[i] = 1'b1;
        m_lat[i] = 1'b1;
      end else if (te) begin
        m_lat[i] = 1'b0;
        m_ov[i]  = 1'b0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    check_eq("level", level, m_level);
    check_eq("rise", rise, m_rise);
    check_eq("fall", fall, m_fall);
    check_eq("latched", latched, m_lat);
    check_eq("overrun", overrun, m_ov);
  end

  int seen, hi, nr, nf;

  initial begin
    model_reset();

    async_in = '1;
    repeat (4) begin
      @(negedge clk);
      tick = ~tick;
    end
    #1;
    check_eq("rst_level", level, 0);
    check_eq("rst_latched", latched, 0);
    check_eq("rst_rise", rise, 0);

    @(negedge clk);
    tick  = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_eq("lvl_before_edge6", level, 4'h0);
    @(posedge clk);
    #1;
    check_eq("lvl_edge6", level, 4'hF);
    check_eq("rise_edge6", rise, 4'hF);
    check_eq("lat_edge6", latched, 4'hF);
    @(posedge clk);
    #1;
    check_eq("rise_edge7", rise, 4'h0);
    check_eq("lvl_edge7", level, 4'hF);

    @(negedge clk);
    async_in = '0;
    repeat (10) @(negedge clk);
    async_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    async_in[0] = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | int'(level[0]) | int'(rise[0]);
    end
    check_eq("glitch3", seen, 0);

    async_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    async_in[0] = 1'b0;
    hi = 0; nr = 0; nf = 0;
    repeat (14) begin
      @(negedge clk);
      hi += int'(level[0]);
      nr += int'(rise[0]);
      nf += int'(fall[0]);
    end
    check_eq("pulse4_high", hi, 4);
    check_eq("pulse4_rise", nr, 1);
    check_eq("pulse4_fall", nf, 1);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) async_in[i] = ~async_in[i];
      if ($urandom_range(11) == 0) tick = ~tick;
      if ($urandom_range(399) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst", {level, rise, fall, latched, overrun}, 0);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
